// File: rtl/sgmii_an_tx_gen.sv
// Clause 37 auto-negotiation transmit symbol generator.
// Emits break-link, config and acknowledge /C/ sets, then /I2/ idles, one pre-8b/10b symbol per clock.
module sgmii_an_tx_gen #(
    parameter int BRK_W    = 32,
    parameter int CNT_W    = 16,
    parameter int ACK_SETS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BRK_W-1:0] breaklink_cycles,
    input  logic [CNT_W-1:0] an_count,
    input  logic [15:0]      an_config,
    output logic [7:0]       tx_data,
    output logic             tx_is_k,
    output logic             busy,
    output logic             done
);

    localparam int CW = (BRK_W > CNT_W) ? BRK_W : CNT_W;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D16_2 = 8'h50;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_CONFIG,
        S_ACK,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            tog_q, tog_d;
    logic            pend_q, pend_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   brk_sets_q, brk_sets_d;
    logic [CW-1:0]   an_q, an_d;
    logic [15:0]     cfg_q, cfg_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_is_k_q, tx_is_k_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept;
    logic [CW-1:0]   brk_in_sets;
    logic [CW-1:0]   brk_eff;
    logic [CW-1:0]   an_eff;
    logic [15:0]     set_cfg;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            tog_q      <= 1'b0;
            pend_q     <= 1'b0;
            rem_q      <= '0;
            brk_sets_q <= '0;
            an_q       <= '0;
            cfg_q      <= 16'h0000;
            tx_data_q  <= K28_5;
            tx_is_k_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tog_q      <= tog_d;
            pend_q     <= pend_d;
            rem_q      <= rem_d;
            brk_sets_q <= brk_sets_d;
            an_q       <= an_d;
            cfg_q      <= cfg_d;
            tx_data_q  <= tx_data_d;
            tx_is_k_q  <= tx_is_k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; state_q/idx_q describe the symbol currently on the output
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tog_d      = tog_q;
        pend_d     = pend_q;
        rem_d      = rem_q;
        brk_sets_d = brk_sets_q;
        an_d       = an_q;
        cfg_d      = cfg_q;

        accept      = ((state_q == S_IDLE) || (state_q == S_DONE)) && !pend_q && start;
        brk_in_sets = CW'(breaklink_cycles >> 2) + CW'(|breaklink_cycles[1:0]);
        brk_eff     = accept ? brk_in_sets : brk_sets_q;
        an_eff      = accept ? CW'(an_count) : an_q;

        if (accept) begin
            brk_sets_d = brk_in_sets;
            an_d       = CW'(an_count);
            cfg_d      = an_config;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (idx_q == 2'd0) begin
                    // /I2/ must finish its D16.2 before the first /C/
                    idx_d = 2'd1;
                    if (accept) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    idx_d = 2'd0;
                    if (accept || pend_q) begin
                        pend_d = 1'b0;
                        tog_d  = 1'b0;
                        if (brk_eff != '0) begin
                            state_d = S_BREAK;
                            rem_d   = brk_eff;
                        end else if (an_eff != '0) begin
                            state_d = S_CONFIG;
                            rem_d   = an_eff;
                        end else begin
                            state_d = S_ACK;
                            rem_d   = CW'(ACK_SETS);
                        end
                    end
                end
            end
            default: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    tog_d = ~tog_q;
                    if (rem_q == CW'(1)) begin
                        case (state_q)
                            S_BREAK: begin
                                if (an_q != '0) begin
                                    state_d = S_CONFIG;
                                    rem_d   = an_q;
                                end else begin
                                    state_d = S_ACK;
                                    rem_d   = CW'(ACK_SETS);
                                end
                            end
                            S_CONFIG: begin
                                state_d = S_ACK;
                                rem_d   = CW'(ACK_SETS);
                            end
                            default: begin
                                state_d = S_DONE;
                                rem_d   = '0;
                            end
                        endcase
                    end else begin
                        rem_d = rem_q - CW'(1);
                    end
                end
            end
        endcase
    end

    // Output logic: symbol for the next state, registered alongside it
    always_comb begin
        tx_data_d = K28_5;
        tx_is_k_d = 1'b1;
        set_cfg   = 16'h0000;

        case (state_d)
            S_CONFIG: set_cfg = cfg_d;
            S_ACK:    set_cfg = cfg_d | 16'h4000;
            default:  set_cfg = 16'h0000;
        endcase

        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            if (idx_d[0]) begin
                tx_data_d = D16_2;
                tx_is_k_d = 1'b0;
            end
        end else begin
            case (idx_d)
                2'd0: begin
                    tx_data_d = K28_5;
                    tx_is_k_d = 1'b1;
                end
                2'd1: begin
                    tx_data_d = tog_d ? D2_2 : D21_5;
                    tx_is_k_d = 1'b0;
                end
                2'd2: begin
                    tx_data_d = set_cfg[7:0];
                    tx_is_k_d = 1'b0;
                end
                default: begin
                    tx_data_d = set_cfg[15:8];
                    tx_is_k_d = 1'b0;
                end
            endcase
        end

        busy_d = pend_d || (state_d == S_BREAK) || (state_d == S_CONFIG) || (state_d == S_ACK);
        done_d = (state_d == S_DONE) && !pend_d;
    end

    assign tx_data = tx_data_q;
    assign tx_is_k = tx_is_k_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sgmii_an_tx_gen.sv
// Directed bench for sgmii_an_tx_gen: checks the symbol stream against hand-built ordered-set sequences.
module tb_sgmii_an_tx_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] breaklink_cycles;
    logic [15:0] an_count;
    logic [15:0] an_config;
    logic [7:0]  tx_data;
    logic        tx_is_k;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       b;
        logic       dn;
    } sym_t;

    sym_t exp_q[$];

    sgmii_an_tx_gen #(
        .BRK_W(32),
        .CNT_W(16),
        .ACK_SETS(3)
    ) dut (
        .clock(clk),
        .reset(rst),
        .start(start),
        .breaklink_cycles(breaklink_cycles),
        .an_count(an_count),
        .an_config(an_config),
        .tx_data(tx_data),
        .tx_is_k(tx_is_k),
        .busy(busy),
        .done(done)
    );

    always #4 clk = ~clk;

    function automatic void push_set(logic tog, logic [15:0] c);
        exp_q.push_back('{d: 8'hBC, k: 1'b1, b: 1'b1, dn: 1'b0});
        exp_q.push_back('{d: (tog ? 8'h42 : 8'hB5), k: 1'b0, b: 1'b1, dn: 1'b0});
        exp_q.push_back('{d: c[7:0], k: 1'b0, b: 1'b1, dn: 1'b0});
        exp_q.push_back('{d: c[15:8], k: 1'b0, b: 1'b1, dn: 1'b0});
    endfunction

    // Expected stream from the first /C/ BC through the first /I2/ after completion
    function automatic void build_exp(int brk, int an, logic [15:0] cfg);
        logic tog;
        int   nb;
        exp_q.delete();
        tog = 1'b0;
        nb  = (brk + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            push_set(tog, 16'h0000);
            tog = ~tog;
        end
        for (int i = 0; i < an; i++) begin
            push_set(tog, cfg);
            tog = ~tog;
        end
        for (int i = 0; i < 3; i++) begin
            push_set(tog, cfg | 16'h4000);
            tog = ~tog;
        end
        exp_q.push_back('{d: 8'hBC, k: 1'b1, b: 1'b0, dn: 1'b1});
        exp_q.push_back('{d: 8'h50, k: 1'b0, b: 1'b0, dn: 1'b1});
    endfunction

    task automatic wait_for_sym(input logic [7:0] s, input string who);
        for (int i = 0; i < 4 && tx_data !== s; i++) @(negedge clk);
        if (tx_data !== s) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s align: got %h, want %h within 4 cycles", who, tx_data, s);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        breaklink_cycles = 32'd0;
        an_count  = 16'd0;
        an_config = 16'h0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_data !== 8'hBC || tx_is_k !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got d=%h k=%b busy=%b done=%b, want d=bc k=1 busy=0 done=0",
                     tx_data, tx_is_k, busy, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx_data !== ((i % 2 == 0) ? 8'h50 : 8'hBC) || tx_is_k !== (i % 2 != 0) ||
                busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=0 done=0",
                         i, tx_data, tx_is_k, busy, done, (i % 2 == 0) ? 8'h50 : 8'hBC, (i % 2 != 0));
            end
        end
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_basic;
        wait_for_sym(8'h50, "basic");
        breaklink_cycles = 32'd8;
        an_count  = 16'd4;
        an_config = 16'h0020;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        breaklink_cycles = 32'd99;
        an_count  = 16'd77;
        an_config = 16'hFFFF;
        build_exp(8, 4, 16'h0020);
        foreach (exp_q[i]) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b || done !== exp_q[i].dn) begin
                n_fail++;
                $display("FAIL basic_sym_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=%b done=%b",
                         i, tx_data, tx_is_k, busy, done, exp_q[i].d, exp_q[i].k, exp_q[i].b, exp_q[i].dn);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_data !== ((i % 2 == 0) ? 8'hBC : 8'h50) || busy !== 1'b0 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_done_hold_%0d: got d=%h busy=%b done=%b, want d=%h busy=0 done=1",
                         i, tx_data, busy, done, (i % 2 == 0) ? 8'hBC : 8'h50);
            end
            @(negedge clk);
        end
        $display("test_basic done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_skip_config;
        wait_for_sym(8'hBC, "skip_config");
        breaklink_cycles = 32'd5;
        an_count  = 16'd0;
        an_config = 16'h01A0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (tx_data !== 8'h50 || tx_is_k !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_config_pending: got d=%h k=%b busy=%b done=%b, want d=50 k=0 busy=1 done=0",
                     tx_data, tx_is_k, busy, done);
        end
        @(negedge clk);
        build_exp(5, 0, 16'h01A0);
        n_checks++;
        if (exp_q.size() != 22) begin
            n_fail++;
            $display("FAIL skip_config_len: got %0d symbols, want 22", exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b || done !== exp_q[i].dn) begin
                n_fail++;
                $display("FAIL skip_config_sym_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=%b done=%b",
                         i, tx_data, tx_is_k, busy, done, exp_q[i].d, exp_q[i].k, exp_q[i].b, exp_q[i].dn);
            end
            @(negedge clk);
        end
        $display("test_skip_config done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_start_held;
        wait_for_sym(8'h50, "start_held");
        breaklink_cycles = 32'd4;
        an_count  = 16'd2;
        an_config = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        build_exp(4, 2, 16'h1234);
        for (int i = 0; i < exp_q.size() - 1; i++) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b || done !== exp_q[i].dn) begin
                n_fail++;
                $display("FAIL held_sym_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=%b done=%b",
                         i, tx_data, tx_is_k, busy, done, exp_q[i].d, exp_q[i].k, exp_q[i].b, exp_q[i].dn);
            end
            @(negedge clk);
        end
        n_checks++;
        if (tx_data !== 8'h50 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL held_reaccept: got d=%h busy=%b done=%b, want d=50 busy=1 done=0", tx_data, busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b || done !== exp_q[i].dn) begin
                n_fail++;
                $display("FAIL held_rerun_sym_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=%b done=%b",
                         i, tx_data, tx_is_k, busy, done, exp_q[i].d, exp_q[i].k, exp_q[i].b, exp_q[i].dn);
            end
            @(negedge clk);
        end
        $display("test_start_held done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_reset_mid_config;
        wait_for_sym(8'h50, "reset_mid");
        breaklink_cycles = 32'd4;
        an_count  = 16'd10;
        an_config = 16'hBEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        build_exp(4, 10, 16'hBEEF);
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b) begin
                n_fail++;
                $display("FAIL reset_mid_sym_%0d: got d=%h k=%b busy=%b, want d=%h k=%b busy=%b",
                         i, tx_data, tx_is_k, busy, exp_q[i].d, exp_q[i].k, exp_q[i].b);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_data !== 8'hBC || tx_is_k !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got d=%h k=%b busy=%b done=%b, want d=bc k=1 busy=0 done=0",
                     tx_data, tx_is_k, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_data !== 8'h50 || tx_is_k !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got d=%h k=%b busy=%b done=%b, want d=50 k=0 busy=0 done=0",
                     tx_data, tx_is_k, busy, done);
        end
        $display("test_reset_mid_config done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_after_reset;
        wait_for_sym(8'h50, "after_reset");
        breaklink_cycles = 32'd12;
        an_count  = 16'd1;
        an_config = 16'h8001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        build_exp(12, 1, 16'h8001);
        foreach (exp_q[i]) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b || done !== exp_q[i].dn) begin
                n_fail++;
                $display("FAIL after_reset_sym_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=%b done=%b",
                         i, tx_data, tx_is_k, busy, done, exp_q[i].d, exp_q[i].k, exp_q[i].b, exp_q[i].dn);
            end
            @(negedge clk);
        end
        $display("test_after_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_long;
        int err_before;
        err_before = n_fail;
        wait_for_sym(8'h50, "long");
        breaklink_cycles = 32'd1001;
        an_count  = 16'd300;
        an_config = 16'hA5C3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        build_exp(1001, 300, 16'hA5C3);
        n_checks++;
        if (exp_q.size() != (251 + 300 + 3) * 4 + 2) begin
            n_fail++;
            $display("FAIL long_len: got %0d symbols, want %0d", exp_q.size(), (251 + 300 + 3) * 4 + 2);
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (tx_data !== exp_q[i].d || tx_is_k !== exp_q[i].k || busy !== exp_q[i].b || done !== exp_q[i].dn) begin
                n_fail++;
                if (n_fail - err_before < 10)
                    $display("FAIL long_sym_%0d: got d=%h k=%b busy=%b done=%b, want d=%h k=%b busy=%b done=%b",
                             i, tx_data, tx_is_k, busy, done, exp_q[i].d, exp_q[i].k, exp_q[i].b, exp_q[i].dn);
            end
            @(negedge clk);
        end
        $display("test_long done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_skip_config();
        test_start_held();
        test_reset_mid_config();
        test_after_reset();
        test_long();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
